// File: rtl/linear_layer_seq.sv
// Time-multiplexed fully-connected layer in signed fixed point.
// One multiply-accumulate per cycle: out[j] = post(sum_i W[j][i]*in[i] + B[j]).
// Neurons are produced one at a time into out_data; the vector is presented
// with a valid/ready handshake once all NOUT neurons are finished.
module linear_layer_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int NIN   = 2,
  parameter int NOUT  = 2,
  parameter logic [WIDTH*NIN*NOUT-1:0] WEIGHTS_FLAT = '0,
  parameter logic [WIDTH*NOUT-1:0]     BIAS_FLAT    = '0,
  parameter int RELU  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH*NIN-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH*NOUT-1:0] out_data,
  output logic                  busy
);

  // Wide enough that NIN full-precision products plus the bias never overflow.
  localparam int ACCW = 2*WIDTH + $clog2(NIN) + 1;
  localparam int IW   = (NIN  > 1) ? $clog2(NIN)  : 1;
  localparam int JW   = (NOUT > 1) ? $clog2(NOUT) : 1;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_r, state_s;
  logic [WIDTH*NIN-1:0]     in_buf_r, in_buf_s;
  logic [IW-1:0]            i_r, i_s;
  logic [JW-1:0]            j_r, j_s;
  logic signed [ACCW-1:0]   acc_r, acc_s;
  logic [WIDTH*NOUT-1:0]    out_data_r, out_data_s;
  logic                     in_ready_r, in_ready_s;
  logic                     out_valid_r, out_valid_s;
  logic                     busy_r, busy_s;

  int                       widx_s;
  logic signed [WIDTH-1:0]  w_s;
  logic signed [WIDTH-1:0]  x_s;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [ACCW-1:0]   sum_s;

  // Bias of neuron k, sign-extended and aligned to the product's binary point.
  function automatic logic signed [ACCW-1:0] bias_acc(input int k);
    logic signed [WIDTH-1:0] b;
    b = BIAS_FLAT[(NOUT-1-k)*WIDTH +: WIDTH];
    return ({{(ACCW-WIDTH){b[WIDTH-1]}}, b}) <<< FRAC;
  endfunction

  // Floor-shift back to Q format, saturate to WIDTH bits, optional ReLU.
  function automatic logic [WIDTH-1:0] post_val(input logic signed [ACCW-1:0] x);
    logic signed [ACCW-1:0] sh;
    logic signed [ACCW-1:0] sat;
    sh = x >>> FRAC;
    if (sh > SAT_MAX) begin
      sat = SAT_MAX;
    end else if (sh < SAT_MIN) begin
      sat = SAT_MIN;
    end else begin
      sat = sh;
    end
    if ((RELU == 1) && sat[ACCW-1]) begin
      sat = '0;
    end else begin
      sat = sat;
    end
    return sat[WIDTH-1:0];
  endfunction

  // Shared datapath: select W[j][i] and in[i], multiply and add to the accumulator.
  always_comb begin
    widx_s = int'(j_r) * NIN + int'(i_r);
    w_s    = WEIGHTS_FLAT[(NIN*NOUT-1-widx_s)*WIDTH +: WIDTH];
    x_s    = in_buf_r[(NIN-1-int'(i_r))*WIDTH +: WIDTH];
    prod_s = w_s * x_s;
    sum_s  = acc_r + {{(ACCW-2*WIDTH){prod_s[2*WIDTH-1]}}, prod_s};
  end

  // Next-state logic; handshake outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_s    = state_r;
    in_buf_s   = in_buf_r;
    i_s        = i_r;
    j_s        = j_r;
    acc_s      = acc_r;
    out_data_s = out_data_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          in_buf_s = in_data;
          i_s      = '0;
          j_s      = '0;
          acc_s    = bias_acc(0);
          state_s  = MAC;
        end else begin
          state_s  = IDLE;
        end
      end
      MAC: begin
        if (i_r == IW'(NIN-1)) begin
          out_data_s[(NOUT-1-int'(j_r))*WIDTH +: WIDTH] = post_val(sum_s);
          i_s = '0;
          if (j_r == JW'(NOUT-1)) begin
            acc_s   = '0;
            state_s = DONE;
          end else begin
            acc_s   = bias_acc(int'(j_r) + 1);
            j_s     = j_r + JW'(1);
          end
        end else begin
          acc_s = sum_s;
          i_s   = i_r + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    in_ready_s  = (state_s == IDLE);
    busy_s      = (state_s == MAC);
    out_valid_s = (state_s == DONE);
  end

  // State, datapath and output registers; reset aborts any vector in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_buf_r    <= '0;
      i_r         <= '0;
      j_r         <= '0;
      acc_r       <= '0;
      out_data_r  <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_buf_r    <= in_buf_s;
      i_r         <= i_s;
      j_r         <= j_s;
      acc_r       <= acc_s;
      out_data_r  <= out_data_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_linear_layer_seq.sv
// Bench for linear_layer_seq: three instances (plain, ReLU, saturation/floor
// weights) driven in lockstep from shared inputs, checked against a
// plain-arithmetic model and a table of hand-computed vectors.
module tb_linear_layer_seq;

  // Weights/bias of the three instances (W00, W01, W10, W11 / B0, B1).
  localparam logic [63:0] WA_FLAT = {16'h0100, 16'hFF80, 16'h0040, 16'h0200}; // 256,-128,64,512
  localparam logic [31:0] BA_FLAT = {16'h0020, 16'hFF00};                     // 32,-256
  localparam logic [63:0] WC_FLAT = {16'h0200, 16'h0200, 16'h0080, 16'h0000}; // 512,512,128,0
  localparam logic [31:0] BC_FLAT = {16'h0000, 16'h0000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        in_ready_a, out_valid_a, busy_a;
  logic        in_ready_b, out_valid_b, busy_b;
  logic        in_ready_c, out_valid_c, busy_c;
  logic [31:0] out_data_a, out_data_b, out_data_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  linear_layer_seq #(.WEIGHTS_FLAT(WA_FLAT), .BIAS_FLAT(BA_FLAT), .RELU(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .busy(busy_a));
  linear_layer_seq #(.WEIGHTS_FLAT(WA_FLAT), .BIAS_FLAT(BA_FLAT), .RELU(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .busy(busy_b));
  linear_layer_seq #(.WEIGHTS_FLAT(WC_FLAT), .BIAS_FLAT(BC_FLAT), .RELU(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c), .busy(busy_c));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: floor shift, saturate, optional ReLU on a plain 64-bit sum.
  function automatic logic [15:0] post(input longint s, input bit relu);
    longint y;
    y = s >>> 8;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    if (relu && y < 0) y = 0;
    return y[15:0];
  endfunction

  function automatic logic [31:0] model(input int w00, input int w01, input int w10, input int w11,
                                        input int b0, input int b1, input bit relu,
                                        input logic signed [15:0] x0, input logic signed [15:0] x1);
    longint s0, s1;
    s0 = longint'(w00) * longint'(x0) + longint'(w01) * longint'(x1) + longint'(b0) * 256;
    s1 = longint'(w10) * longint'(x0) + longint'(w11) * longint'(x1) + longint'(b1) * 256;
    return {post(s0, relu), post(s1, relu)};
  endfunction

  // Present one vector, measure latency and busy, leave the block in DONE.
  task automatic run_vec(input logic [15:0] x0, input logic [15:0] x1,
                         output logic [31:0] ra, output logic [31:0] rb, output logic [31:0] rc);
    int lat;
    @(negedge clk);
    chk("ready_before_accept", in_ready_a, 1);
    in_data  = {x0, x1};
    in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    while (!out_valid_a && lat < 20) begin
      chk("busy_in_mac", {busy_a, busy_b, busy_c, in_ready_a}, 4'b1110);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, 4);
    chk("done_flags", {out_valid_b, out_valid_c, busy_a, in_ready_a}, 4'b1100);
    ra = out_data_a;
    rb = out_data_b;
    rc = out_data_c;
  endtask

  // Complete the output handshake and confirm return to IDLE.
  task automatic finish_vec();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_handshake", {out_valid_a, in_ready_a, busy_a}, 3'b010);
  endtask

  typedef struct {
    logic [15:0] x0, x1;
    logic [31:0] exp_a, exp_b, exp_c;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [31:0] ra, rb, rc, held;
    logic [15:0] x0, x1;

    // Hand-computed vectors: nominal, both saturation rails, floor rounding.
    tbl[0] = '{16'd384,   16'hFFC0, {16'd448,   16'hFEE0}, {16'd448,   16'd0},    {16'd640,   16'd192}};
    tbl[1] = '{16'h7FFF,  16'h7FFF, {16'd16415, 16'h7FFF}, {16'd16415, 16'h7FFF}, {16'h7FFF,  16'd16383}};
    tbl[2] = '{16'h8000,  16'h8000, {16'hC020,  16'h8000}, {16'd0,     16'd0},    {16'h8000,  16'hC000}};
    tbl[3] = '{16'd1,     16'd0,    {16'd33,    16'hFF00}, {16'd33,    16'd0},    {16'd2,     16'd0}};
    tbl[4] = '{16'hFFFF,  16'd0,    {16'd31,    16'hFEFF}, {16'd31,    16'd0},    {16'hFFFE,  16'hFFFF}};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {in_ready_a, out_valid_a, busy_a, out_data_a}, {3'b100, 32'd0});
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int k = 0; k < 5; k++) begin
      run_vec(tbl[k].x0, tbl[k].x1, ra, rb, rc);
      chk($sformatf("tbl%0d_a", k), ra, tbl[k].exp_a);
      chk($sformatf("tbl%0d_relu", k), rb, tbl[k].exp_b);
      chk($sformatf("tbl%0d_c", k), rc, tbl[k].exp_c);
      finish_vec();
    end

    // Backpressure: output held, input ignored for 10 cycles.
    run_vec(16'd384, 16'hFFC0, ra, rb, rc);
    held = ra;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = k[0];
      in_data  = $urandom;
      chk("bp_hold", {out_valid_a, in_ready_a, out_data_a}, {2'b10, held});
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_vec();
    run_vec(16'd1, 16'd0, ra, rb, rc);
    chk("after_bp_a", ra, 32'h0021FF00);
    finish_vec();
    run_vec(16'hFFFF, 16'd0, ra, rb, rc);
    chk("after_bp_c", rc, 32'hFFFEFFFF);
    finish_vec();

    // Reset two cycles into MAC: aborted, nothing emitted.
    @(negedge clk);
    in_data = {16'h7FFF, 16'h7FFF};
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("mid_reset", {out_valid_a, in_ready_a, busy_a, out_data_a}, {3'b010, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("no_emit_after_abort", {out_valid_a, out_valid_c}, 2'b00);
    run_vec(16'd384, 16'hFFC0, ra, rb, rc);
    chk("fresh_after_reset_a", ra, 32'h01C0FEE0);
    chk("fresh_after_reset_c", rc, 32'h028000C0);
    finish_vec();

    // Random vectors against the reference model.
    for (int k = 0; k < 40; k++) begin
      if (k[0]) begin
        x0 = 16'($urandom);
        x1 = 16'($urandom);
      end else begin
        x0 = 16'($urandom_range(0, 2047) - 1024);
        x1 = 16'($urandom_range(0, 2047) - 1024);
      end
      run_vec(x0, x1, ra, rb, rc);
      chk($sformatf("rnd%0d_a", k), ra, model(256, -128, 64, 512, 32, -256, 1'b0, x0, x1));
      chk($sformatf("rnd%0d_relu", k), rb, model(256, -128, 64, 512, 32, -256, 1'b1, x0, x1));
      chk($sformatf("rnd%0d_c", k), rc, model(512, 512, 128, 0, 0, 0, 1'b0, x0, x1));
      finish_vec();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/linear_layer_seq.md
Name: linear_layer_seq

Overview:
- Time-multiplexed, parametrised fully-connected layer in signed Qm.FRAC fixed point.
- Computes out[j] = sat(sum_i W[j][i]*in[i] + B[j]) for NOUT neurons over NIN inputs using one shared multiplier-accumulator.
- Valid/ready streaming interface on input and output; one vector in flight.
- Optional ReLU.
- Sequential successor to the combinational neuron array, for layers too wide to unroll.

Parameters:
- WIDTH, 16, total bits per element (signed, two's complement).
- FRAC, 8, fractional bits (Q(WIDTH-FRAC).FRAC); 0 <= FRAC < WIDTH.
- NIN, 2, inputs per neuron; >= 1.
- NOUT, 2, neurons (outputs); >= 1.
- WEIGHTS_FLAT, 0, WIDTH*NIN*NOUT bits; W[0][0] in the MSBs, row-major (neuron j, input i at element index j*NIN+i counted from MSB).
- BIAS_FLAT, 0, WIDTH*NOUT bits; B[0] in the MSBs.
- RELU, 0, 1 = clamp negative results to 0 after saturation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a vector
- in_data  input  WIDTH*NIN  input vector, element 0 in MSBs
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- out_data  output  WIDTH*NOUT  result vector, element 0 in MSBs
- busy  output  1  high in MAC state

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, accumulator and counters=0.
- Reset mid-operation aborts the vector; nothing is emitted.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1.
  - Accept edge when in_valid && in_ready.
  - On that edge: latch in_data internally (input may change afterwards), set i=0, j=0, acc=B[0]<<<FRAC (sign-extended), go to MAC.
- MAC:
  - in_ready=0, busy=1.
  - Each cycle: sum = acc + W[j][i]*in[i] (full-precision signed product, 2*WIDTH bits).
  - If i<NIN-1: acc<=sum, i<=i+1.
  - If i==NIN-1: out[j] <= post(sum), i<=0, acc<=B[j+1]<<<FRAC.
    - If j==NOUT-1: go to DONE.
    - Otherwise: j<=j+1.
- Accumulator width: 2*WIDTH + clog2(NIN) + 1; it never overflows internally.
- post(x):
  - Arithmetic shift right by FRAC (floor, i.e. truncation toward negative infinity).
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If RELU=1, negative results become 0.
- Latency: out_valid rises exactly NIN*NOUT cycles after the accept edge (4 for the 2x2 default).
- DONE:
  - out_valid=1; out_data held stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready: out_valid<=0, go to IDLE.
  - in_ready is 0 in DONE; a new vector is accepted no earlier than the cycle after the output handshake.
- out_data retains its last values after the output handshake until overwritten neuron by neuron during the next MAC pass.
- in_valid is ignored when in_ready=0. in_data contents are don't-care when in_valid=0.
- out_ready has no effect outside DONE.

Test Plan:
- Default params, WEIGHTS {256,-128,64,512}, BIAS {32,-256}, in {384,-64}, out_ready=1:
  - out_data = {448,-288} (1.75, -1.125).
  - out_valid rises 4 cycles after the accept edge; busy high for those 4 cycles.
- Same vectors, RELU=1 -> out_data = {448,0}.
- Saturation: W row0 {512,512}, B {0,...}:
  - in {32767,32767} -> out[0]=32767.
  - in {-32768,-32768} -> out[0]=-32768.
- Floor rounding: W row0 {128,0}, B0=0:
  - in {1,0} -> out[0]=0.
  - in {-1,0} -> out[0]=-1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, in_valid pulses ignored.
  - Release out_ready -> one handshake, IDLE next cycle.
  - Then back-to-back vectors produce correct results in order.
- Reset: assert rst_n=0 two cycles into MAC -> immediately out_valid=0, in_ready=1, out_data=0.
  - After release, a fresh vector yields the correct result with no residue from the aborted one.
